// File: rtl/ara_mem_init_ctrl.sv
// ara_mem_init_ctrl: memory bring-up sequencer and port arbiter for the Ara
// SoC DRAM (L2) and RRAM row-wide macros.
//
// In INIT the preload writer owns both memories and streams full rows.
// A last beat or start_i hands the ports over to the system requester (RUN),
// which is granted combinationally and never stalled.
//
// Build option: define RRAM_REGION_EN to decode the RRAM region. Without it,
// the rram_* outputs are held at zero and RRAM-range addresses are treated
// as out-of-region.
//
// state | meaning
// INIT  | preload writer owns the memories, system held off
// RUN   | system requester owns the memories for the rest of the run
module ara_mem_init_ctrl #(
  parameter int unsigned                 AddrWidth   = 64,
  parameter int unsigned                 DataWidth   = 512,
  parameter logic [AddrWidth-1:0]        DramBase    = 'h8000_0000,
  parameter logic [AddrWidth-1:0]        DramLength  = 'h4000_0000,
  parameter logic [AddrWidth-1:0]        RramBase    = 'h1000_0000,
  parameter logic [AddrWidth-1:0]        RramLength  = 'h4000_0000,
  parameter int unsigned                 RowIdxWidth = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     pl_valid_i,
  output logic                     pl_ready_o,
  input  logic [AddrWidth-1:0]     pl_addr_i,
  input  logic [DataWidth-1:0]     pl_data_i,
  input  logic                     pl_last_i,
  input  logic                     start_i,
  input  logic                     sys_req_i,
  output logic                     sys_gnt_o,
  input  logic                     sys_we_i,
  input  logic [AddrWidth-1:0]     sys_addr_i,
  input  logic [DataWidth-1:0]     sys_wdata_i,
  input  logic [DataWidth/8-1:0]   sys_be_i,
  output logic                     sys_rvalid_o,
  output logic [DataWidth-1:0]     sys_rdata_o,
  output logic                     sys_err_o,
  output logic                     dram_req_o,
  output logic                     dram_we_o,
  output logic [RowIdxWidth-1:0]   dram_addr_o,
  output logic [DataWidth-1:0]     dram_wdata_o,
  output logic [DataWidth/8-1:0]   dram_be_o,
  input  logic [DataWidth-1:0]     dram_rdata_i,
  output logic                     rram_req_o,
  output logic                     rram_we_o,
  output logic [RowIdxWidth-1:0]   rram_addr_o,
  output logic [DataWidth-1:0]     rram_wdata_o,
  output logic [DataWidth/8-1:0]   rram_be_o,
  input  logic [DataWidth-1:0]     rram_rdata_i,
  output logic                     init_done_o,
  output logic [15:0]              skip_cnt_o
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned OffBits = $clog2(BeWidth);

  typedef enum logic {INIT, RUN} state_e;

  state_e                   state_q;
  logic                     pl_ready_q;
  logic                     init_done_q;
  logic [15:0]              skip_q;
  logic                     rvalid_q;
  logic                     err_q;
  logic                     sel_dram_q;
  logic                     sel_rram_q;

  logic                     run;
  logic                     acc_valid;
  logic [AddrWidth-1:0]     acc_addr;
  logic [DataWidth-1:0]     acc_wdata;
  logic [BeWidth-1:0]       acc_be;
  logic                     acc_we;
  logic                     hit_dram;
  logic                     hit_rram;
  logic                     miss;

  function automatic logic in_range(input logic [AddrWidth-1:0] a,
                                    input logic [AddrWidth-1:0] base,
                                    input logic [AddrWidth-1:0] len);
    return (a >= base) && (a < base + len);
  endfunction

  function automatic logic [RowIdxWidth-1:0] row_idx(input logic [AddrWidth-1:0] a,
                                                     input logic [AddrWidth-1:0] base);
    logic [AddrWidth-1:0] off;
    off = (a - base) >> OffBits;
    return off[RowIdxWidth-1:0];
  endfunction

  // Port ownership follows the FSM: preload in INIT, system in RUN.
  assign run       = (state_q == RUN);
  assign acc_valid = ~rst_i & (run ? sys_req_i : pl_valid_i);
  assign acc_addr  = run ? sys_addr_i  : pl_addr_i;
  assign acc_wdata = run ? sys_wdata_i : pl_data_i;
  assign acc_be    = run ? sys_be_i    : {BeWidth{1'b1}};
  assign acc_we    = run ? sys_we_i    : 1'b1;

  assign hit_dram  = in_range(acc_addr, DramBase, DramLength);
`ifdef RRAM_REGION_EN
  assign hit_rram  = ~hit_dram & in_range(acc_addr, RramBase, RramLength);
`else
  assign hit_rram  = 1'b0;
`endif
  assign miss      = ~hit_dram & ~hit_rram;

  assign dram_req_o   = acc_valid & hit_dram;
  assign dram_we_o    = acc_we;
  assign dram_addr_o  = row_idx(acc_addr, DramBase);
  assign dram_wdata_o = acc_wdata;
  assign dram_be_o    = acc_be;

`ifdef RRAM_REGION_EN
  assign rram_req_o   = acc_valid & hit_rram;
  assign rram_we_o    = acc_we;
  assign rram_addr_o  = row_idx(acc_addr, RramBase);
  assign rram_wdata_o = acc_wdata;
  assign rram_be_o    = acc_be;
`else
  logic unused_rram_rdata;
  assign unused_rram_rdata = ^rram_rdata_i;
  assign rram_req_o   = 1'b0;
  assign rram_we_o    = 1'b0;
  assign rram_addr_o  = '0;
  assign rram_wdata_o = '0;
  assign rram_be_o    = '0;
`endif

  assign sys_gnt_o    = run & sys_req_i & ~rst_i;
  assign sys_rvalid_o = rvalid_q & ~rst_i;
  assign sys_err_o    = err_q & ~rst_i;
  assign sys_rdata_o  = ~sys_rvalid_o ? '0 :
                        sel_dram_q    ? dram_rdata_i :
                        sel_rram_q    ? rram_rdata_i : '0;

  assign pl_ready_o   = pl_ready_q;
  assign init_done_o  = init_done_q;
  assign skip_cnt_o   = skip_q;

  // Bring-up FSM: count dropped preload rows, hand over on last beat or start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      pl_ready_q  <= 1'b1;
      init_done_q <= 1'b0;
      skip_q      <= '0;
    end else begin
      case (state_q)
        INIT: begin
          if (pl_valid_i && miss && (skip_q != 16'hFFFF)) skip_q <= skip_q + 16'd1;
          if ((pl_valid_i && pl_last_i) || start_i) begin
            state_q     <= RUN;
            pl_ready_q  <= 1'b0;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= RUN;
          pl_ready_q  <= 1'b0;
          init_done_q <= 1'b1;
        end
      endcase
    end
  end

  // Read response pipeline: remember which region answers one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      sel_dram_q <= 1'b0;
      sel_rram_q <= 1'b0;
    end else begin
      rvalid_q   <= sys_gnt_o & ~sys_we_i;
      err_q      <= sys_gnt_o & miss;
      sel_dram_q <= hit_dram;
      sel_rram_q <= hit_rram;
    end
  end

endmodule

// File: tb/tb_ara_mem_init_ctrl.sv
// Randomized bench for ara_mem_init_ctrl with a behavioural reference model.
module tb_ara_mem_init_ctrl;

  localparam logic [63:0] DRAM_B = 64'h8000_0000;
  localparam logic [63:0] DRAM_L = 64'h4000_0000;
  localparam logic [63:0] RRAM_B = 64'h1000_0000;
  localparam logic [63:0] RRAM_L = 64'h4000_0000;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         pl_valid_i = 1'b0, pl_last_i = 1'b0, start_i = 1'b0;
  logic [63:0]  pl_addr_i = '0;
  logic [511:0] pl_data_i = '0;
  logic         sys_req_i = 1'b0, sys_we_i = 1'b0;
  logic [63:0]  sys_addr_i = '0;
  logic [511:0] sys_wdata_i = '0;
  logic [63:0]  sys_be_i = '0;
  logic [511:0] dram_rdata_i = '0, rram_rdata_i = '0;

  logic         pl_ready_o, sys_gnt_o, sys_rvalid_o, sys_err_o;
  logic [511:0] sys_rdata_o, dram_wdata_o, rram_wdata_o;
  logic         dram_req_o, dram_we_o, rram_req_o, rram_we_o, init_done_o;
  logic [23:0]  dram_addr_o, rram_addr_o;
  logic [63:0]  dram_be_o, rram_be_o;
  logic [15:0]  skip_cnt_o;

  ara_mem_init_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .pl_valid_i(pl_valid_i), .pl_ready_o(pl_ready_o), .pl_addr_i(pl_addr_i),
    .pl_data_i(pl_data_i), .pl_last_i(pl_last_i), .start_i(start_i),
    .sys_req_i(sys_req_i), .sys_gnt_o(sys_gnt_o), .sys_we_i(sys_we_i),
    .sys_addr_i(sys_addr_i), .sys_wdata_i(sys_wdata_i), .sys_be_i(sys_be_i),
    .sys_rvalid_o(sys_rvalid_o), .sys_rdata_o(sys_rdata_o), .sys_err_o(sys_err_o),
    .dram_req_o(dram_req_o), .dram_we_o(dram_we_o), .dram_addr_o(dram_addr_o),
    .dram_wdata_o(dram_wdata_o), .dram_be_o(dram_be_o), .dram_rdata_i(dram_rdata_i),
    .rram_req_o(rram_req_o), .rram_we_o(rram_we_o), .rram_addr_o(rram_addr_o),
    .rram_wdata_o(rram_wdata_o), .rram_be_o(rram_be_o), .rram_rdata_i(rram_rdata_i),
    .init_done_o(init_done_o), .skip_cnt_o(skip_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: ownership phase, drop count, and the response owed next cycle.
  bit          m_run = 0;
  int          m_skip = 0;
  bit          m_rv = 0;
  int          m_rreg = 0;
  bit          m_err = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 0 = out-of-region, 1 = DRAM, 2 = RRAM
  function automatic int region(input logic [63:0] a);
    if (a >= DRAM_B && a < DRAM_B + DRAM_L) return 1;
`ifdef RRAM_REGION_EN
    if (a >= RRAM_B && a < RRAM_B + RRAM_L) return 2;
`endif
    return 0;
  endfunction

  function automatic logic [23:0] row(input logic [63:0] a, input logic [63:0] base);
    logic [63:0] d;
    d = (a - base) / 64;
    return d[23:0];
  endfunction

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] edges [7];
    edges[0] = DRAM_B - 64;          edges[1] = DRAM_B + DRAM_L - 64;
    edges[2] = DRAM_B + DRAM_L;      edges[3] = RRAM_B - 64;
    edges[4] = RRAM_B + RRAM_L - 64; edges[5] = RRAM_B + RRAM_L;
    edges[6] = 64'h0;
    case ($urandom_range(0, 5))
      0, 1:    return DRAM_B + 64'($urandom_range(0, 24'hFFFFFF)) * 64;
      2:       return RRAM_B + 64'($urandom_range(0, 24'hFFFFFF)) * 64;
      3:       return {$urandom, $urandom};
      4:       return edges[$urandom_range(0, 6)];
      default: return DRAM_B + 64'($urandom_range(0, 4095));
    endcase
  endfunction

  // Compare every DUT output against what the model says this cycle must show.
  task automatic compare();
    int r;
    bit req;
    logic [63:0]  a;
    logic [511:0] wd;
    logic [63:0]  be;
    bit we;
    if (rst_i) return;
    req = m_run ? sys_req_i : pl_valid_i;
    a   = m_run ? sys_addr_i : pl_addr_i;
    wd  = m_run ? sys_wdata_i : pl_data_i;
    be  = m_run ? sys_be_i : 64'hFFFF_FFFF_FFFF_FFFF;
    we  = m_run ? sys_we_i : 1'b1;
    r   = region(a);
    chk("pl_ready", pl_ready_o, !m_run);
    chk("sys_gnt", sys_gnt_o, m_run && sys_req_i);
    chk("init_done", init_done_o, m_run);
    chk("skip_cnt", skip_cnt_o, m_skip);
    chk("dram_req", dram_req_o, req && r == 1);
    chk("rram_req", rram_req_o, req && r == 2);
    if (req && r == 1) begin
      chk("dram_addr", dram_addr_o, row(a, DRAM_B));
      chk("dram_we", dram_we_o, we);
      chk("dram_be", dram_be_o, be);
      chk("dram_wdata", dram_wdata_o, wd);
    end
`ifdef RRAM_REGION_EN
    if (req && r == 2) begin
      chk("rram_addr", rram_addr_o, row(a, RRAM_B));
      chk("rram_we", rram_we_o, we);
      chk("rram_be", rram_be_o, be);
      chk("rram_wdata", rram_wdata_o, wd);
    end
`else
    chk("rram_tied", {rram_we_o, rram_addr_o, rram_be_o, rram_wdata_o[31:0]}, '0);
`endif
    chk("sys_rvalid", sys_rvalid_o, m_rv);
    chk("sys_err", sys_err_o, m_err);
    if (m_rv)
      chk("sys_rdata", sys_rdata_o,
          m_rreg == 1 ? dram_rdata_i : m_rreg == 2 ? rram_rdata_i : 512'h0);
  endtask

  task automatic update();
    int rp, rs;
    rp = region(pl_addr_i);
    rs = region(sys_addr_i);
    if (rst_i) begin
      m_run = 0; m_skip = 0; m_rv = 0; m_rreg = 0; m_err = 0;
      return;
    end
    m_rv   = m_run && sys_req_i && !sys_we_i;
    m_err  = m_run && sys_req_i && rs == 0;
    m_rreg = rs;
    if (!m_run) begin
      if (pl_valid_i && rp == 0 && m_skip < 16'hFFFF) m_skip++;
      if ((pl_valid_i && pl_last_i) || start_i) m_run = 1;
    end
  endtask

  task automatic sample(); @(negedge clk); compare(); endtask
  task automatic adv();    @(posedge clk); update(); #1; endtask
  task automatic cyc();    sample(); adv(); endtask

  task automatic idle();
    pl_valid_i = 0; pl_last_i = 0; start_i = 0; sys_req_i = 0; sys_we_i = 0;
  endtask

  task automatic do_reset();
    idle(); rst_i = 1; cyc(); rst_i = 0;
  endtask

  initial begin
    logic [511:0] pat;
    #1;
    do_reset();

    sample();
    chk("rst_pl_ready", pl_ready_o, 1'b1);
    chk("rst_gnt", sys_gnt_o, 1'b0);
    chk("rst_rvalid", sys_rvalid_o, 1'b0);
    chk("rst_err", sys_err_o, 1'b0);
    chk("rst_reqs", {dram_req_o, rram_req_o}, 2'b00);
    chk("rst_init_done", init_done_o, 1'b0);
    chk("rst_skip", skip_cnt_o, 16'd0);
    adv();

    // Three-row DRAM preload, last on the third.
    for (int i = 0; i < 3; i++) begin
      pl_valid_i = 1; pl_addr_i = 64'h8000_0000 + 64'(i) * 64;
      pl_data_i = rand_data(); pl_last_i = (i == 2);
      sample();
      chk("pre_dram_req", dram_req_o, 1'b1);
      chk("pre_dram_row", dram_addr_o, 24'(i));
      chk("pre_dram_be", dram_be_o, 64'hFFFF_FFFF_FFFF_FFFF);
      adv();
    end
    idle();
    sample();
    chk("pre_init_done", init_done_o, 1'b1);
    adv();

    // RRAM-range preload beat.
    do_reset();
    pl_valid_i = 1; pl_addr_i = 64'h1000_0040; pl_data_i = rand_data();
    sample();
`ifdef RRAM_REGION_EN
    chk("rram_beat_req", rram_req_o, 1'b1);
    chk("rram_beat_row", rram_addr_o, 24'd1);
`else
    chk("rram_beat_noreq", {dram_req_o, rram_req_o}, 2'b00);
`endif
    adv();
    idle();
    sample();
`ifdef RRAM_REGION_EN
    chk("rram_beat_skip", skip_cnt_o, 16'd0);
`else
    chk("rram_beat_skip", skip_cnt_o, 16'd1);
`endif
    adv();

    // Out-of-region beats saturate the drop counter.
    do_reset();
    pl_valid_i = 1; pl_addr_i = 64'h0000_1000;
    cyc();
    sample();
    chk("skip_one", skip_cnt_o, 16'd1);
    adv();
    for (int i = 0; i < 70000; i++) cyc();
    idle();
    sample();
    chk("skip_sat", skip_cnt_o, 16'hFFFF);
    adv();

    // Hand over via start_i, then system read of DRAM row 1.
    start_i = 1; cyc(); idle();
    sys_req_i = 1; sys_we_i = 0; sys_addr_i = 64'h8000_0040;
    sample();
    chk("rd_gnt", sys_gnt_o, 1'b1);
    chk("rd_dram_row", dram_addr_o, 24'd1);
    adv();
    idle();
    for (int i = 0; i < 64; i++) pat[i*8 +: 8] = 8'hA5;
    dram_rdata_i = pat;
    sample();
    chk("rd_rvalid", sys_rvalid_o, 1'b1);
    chk("rd_rdata", sys_rdata_o, pat);
    chk("rd_err", sys_err_o, 1'b0);
    adv();

    // Out-of-region write then read.
    sys_req_i = 1; sys_we_i = 1; sys_addr_i = 64'h0;
    sample();
    chk("oor_wr_noreq", {dram_req_o, rram_req_o}, 2'b00);
    adv();
    idle();
    sample();
    chk("oor_wr_err", sys_err_o, 1'b1);
    chk("oor_wr_norv", sys_rvalid_o, 1'b0);
    adv();
    sample();
    chk("oor_wr_err_end", sys_err_o, 1'b0);
    adv();
    sys_req_i = 1; sys_we_i = 0; sys_addr_i = 64'h0;
    cyc();
    idle();
    sample();
    chk("oor_rd_rvalid", sys_rvalid_o, 1'b1);
    chk("oor_rd_rdata", sys_rdata_o, 512'h0);
    chk("oor_rd_err", sys_err_o, 1'b1);
    adv();

    // start_i with a non-last beat, then reset right after a granted read.
    do_reset();
    pl_valid_i = 1; pl_addr_i = 64'h8000_0100; pl_last_i = 0; start_i = 1;
    sample();
    chk("sb_dram_req", dram_req_o, 1'b1);
    chk("sb_dram_row", dram_addr_o, 24'd4);
    adv();
    idle();
    sys_req_i = 1; sys_addr_i = 64'h8000_0000;
    sample();
    chk("sb_run_gnt", sys_gnt_o, 1'b1);
    adv();
    idle();
    rst_i = 1; cyc(); rst_i = 0;
    sample();
    chk("sb_rst_rvalid", sys_rvalid_o, 1'b0);
    chk("sb_rst_ready", pl_ready_o, 1'b1);
    chk("sb_rst_init", init_done_o, 1'b0);
    adv();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst_i       = ($urandom_range(0, 299) == 0);
      pl_valid_i  = $urandom_range(0, 1);
      pl_addr_i   = rand_addr();
      pl_data_i   = rand_data();
      pl_last_i   = ($urandom_range(0, 19) == 0);
      start_i     = ($urandom_range(0, 49) == 0);
      sys_req_i   = $urandom_range(0, 1);
      sys_we_i    = $urandom_range(0, 1);
      sys_addr_i  = rand_addr();
      sys_wdata_i = rand_data();
      sys_be_i    = {$urandom, $urandom};
      dram_rdata_i = rand_data();
      rram_rdata_i = rand_data();
      cyc();
    end
    rst_i = 0;
    idle();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
